// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: ALU op codes for the
// memory instructions, bus widths, the access state enum and small decode
// helpers. The optional LL/SC reservation bit is enabled by MEM_LLSC_EN
// (consumed in mem_access.sv).
package mem_access_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_LB_OP   = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP  = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP   = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP  = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP   = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP   = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP   = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP   = 8'b1110_1011;
  localparam logic [7:0] EXE_LL_OP   = 8'b1111_0000;
  localparam logic [7:0] EXE_SC_OP   = 8'b1111_1000;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT_GNT,
    MEM_WAIT_DATA,
    MEM_DONE
  } mem_state_t;

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP) || (op == EXE_LL_OP);
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP) ||
           (op == EXE_SC_OP);
  endfunction

  function automatic logic is_byte_op(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_SB_OP);
  endfunction

  function automatic logic is_half_op(input logic [7:0] op);
    return (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
  endfunction

  // Halfword ops need an even address, word ops (incl. LL/SC) a word-aligned one.
  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (is_half_op(op)) begin
      bad = lo[0];
    end else if (!is_byte_op(op) && (is_load_op(op) || is_store_op(op))) begin
      bad = (lo != 2'b00);
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load alignment: picks the addressed byte/halfword out of the registered
// read word (little-endian) and sign- or zero-extends it.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_q,
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  output logic [31:0] ld_result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane selection driven purely by the low address bits.
  always_comb begin
    sel_byte = 8'h00;
    case (addr_lo)
      2'd0:    sel_byte = rdata_q[7:0];
      2'd1:    sel_byte = rdata_q[15:8];
      2'd2:    sel_byte = rdata_q[23:16];
      default: sel_byte = rdata_q[31:24];
    endcase
    sel_half = addr_lo[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  // Extension according to the load flavour; word loads pass untouched.
  always_comb begin
    ld_result = rdata_q;
    case (aluop)
      EXE_LB_OP:  ld_result = {{24{sel_byte[7]}}, sel_byte};
      EXE_LBU_OP: ld_result = {24'h000000, sel_byte};
      EXE_LH_OP:  ld_result = {{16{sel_half[15]}}, sel_half};
      EXE_LHU_OP: ld_result = {16'h0000, sel_half};
      default:    ld_result = rdata_q;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MIPS32 memory-access stage. Forwards write-back info to mem_wb, runs a
// req/gnt/rvalid data-bus handshake for loads/stores while stalling the
// pipeline, steers store lanes and extends load data.
// Optional feature: MEM_LLSC_EN adds the LL reservation bit and the
// llbit_clr input; without it SC always succeeds.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [REG_BUS_W-1:0]  ex_wdata,
  input  logic [31:0]           ex_hi,
  input  logic [31:0]           ex_lo,
  input  logic                  ex_whilo,
  input  logic [7:0]            ex_aluop,
  input  logic [31:0]           ex_mem_addr,
  input  logic [31:0]           ex_reg2,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [REG_BUS_W-1:0]  mem_wdata,
  output logic [31:0]           mem_hi,
  output logic [31:0]           mem_lo,
  output logic                  mem_whilo,
  output logic                  stallreq_mem,
  output logic                  mem_adel,
  output logic                  mem_ades,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [3:0]            dbus_be,
  output logic [31:0]           dbus_addr,
  output logic [31:0]           dbus_wdata,
`ifdef MEM_LLSC_EN
  input  logic                  llbit_clr,
`endif
  input  logic                  dbus_gnt,
  input  logic                  dbus_rvalid,
  input  logic [31:0]           dbus_rdata
);

  mem_state_t  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_raw;
  logic        is_ld, is_st, is_sc, misalign, sc_fail, bus_op;
  logic [31:0] ld_result;
  logic [31:0] sc_result;

  assign is_ld    = is_load_op(ex_aluop);
  assign is_st    = is_store_op(ex_aluop);
  assign is_sc    = (ex_aluop == EXE_SC_OP);
  assign misalign = is_misaligned(ex_aluop, ex_mem_addr[1:0]);

`ifdef MEM_LLSC_EN
  logic llbit_q, llbit_d;

  // A failing SC is decided before any bus activity; once an access is in
  // flight the SC is committed and reports success.
  assign sc_fail   = is_sc && !llbit_q && (state_q == MEM_IDLE);
  assign sc_result = ((state_q != MEM_IDLE) || llbit_q) ? 32'd1 : 32'd0;

  // Reservation bit: clear has priority, LL sets on completion, SC consumes it.
  always_comb begin
    llbit_d = llbit_q;
    if (llbit_clr) begin
      llbit_d = 1'b0;
    end else if ((ex_aluop == EXE_LL_OP) && !misalign && (state_q == MEM_DONE)) begin
      llbit_d = 1'b1;
    end else if (is_sc && ((state_q == MEM_DONE) || sc_fail)) begin
      llbit_d = 1'b0;
    end
  end

  // Reservation bit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      llbit_q <= 1'b0;
    end else begin
      llbit_q <= llbit_d;
    end
  end
`else
  assign sc_fail   = 1'b0;
  assign sc_result = 32'd1;
`endif

  // Only aligned memory ops that actually need the bus occupy the FSM.
  assign bus_op = (is_ld || is_st) && !misalign && !sc_fail;

  // Access sequencing: request until granted, wait for the response, then
  // spend exactly one cycle presenting the result.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    req_raw = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (bus_op) begin
          req_raw = 1'b1;
          state_d = dbus_gnt ? MEM_WAIT_DATA : MEM_WAIT_GNT;
        end
      end
      MEM_WAIT_GNT: begin
        req_raw = 1'b1;
        if (dbus_gnt) begin
          state_d = MEM_WAIT_DATA;
        end
      end
      MEM_WAIT_DATA: begin
        if (dbus_rvalid) begin
          rdata_d = dbus_rdata;
          state_d = MEM_DONE;
        end
      end
      MEM_DONE: begin
        state_d = MEM_IDLE;
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase
  end

  // State and read-data registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  mem_load_align u_load_align (
    .rdata_q   (rdata_q),
    .aluop     (ex_aluop),
    .addr_lo   (ex_mem_addr[1:0]),
    .ld_result (ld_result)
  );

  // Bus-side drive: word address, lane enables and replicated store data.
  always_comb begin
    dbus_req   = req_raw && !rst;
    dbus_we    = 1'b0;
    dbus_be    = 4'b0000;
    dbus_addr  = 32'h0;
    dbus_wdata = 32'h0;
    if (bus_op && !rst) begin
      dbus_we   = is_st;
      dbus_addr = {ex_mem_addr[31:2], 2'b00};
      if (is_byte_op(ex_aluop)) begin
        dbus_be = 4'b0001 << ex_mem_addr[1:0];
      end else if (is_half_op(ex_aluop)) begin
        dbus_be = 4'b0011 << ex_mem_addr[1:0];
      end else begin
        dbus_be = 4'b1111;
      end
      if (is_st) begin
        if (is_byte_op(ex_aluop)) begin
          dbus_wdata = {4{ex_reg2[7:0]}};
        end else if (is_half_op(ex_aluop)) begin
          dbus_wdata = {2{ex_reg2[15:0]}};
        end else begin
          dbus_wdata = ex_reg2;
        end
      end
    end
  end

  // Pipeline-side results toward mem_wb, plus stall and address-error flags.
  always_comb begin
    mem_wd       = '0;
    mem_wreg     = 1'b0;
    mem_wdata    = '0;
    mem_hi       = 32'h0;
    mem_lo       = 32'h0;
    mem_whilo    = 1'b0;
    stallreq_mem = 1'b0;
    mem_adel     = 1'b0;
    mem_ades     = 1'b0;
    if (!rst) begin
      mem_wd       = ex_wd;
      mem_wreg     = ex_wreg;
      mem_wdata    = ex_wdata;
      mem_hi       = ex_hi;
      mem_lo       = ex_lo;
      mem_whilo    = ex_whilo;
      stallreq_mem = bus_op && (state_q != MEM_DONE);
      if (is_ld) begin
        mem_wdata = ld_result;
      end
      if (is_st) begin
        mem_wreg = 1'b0;
      end
      if (is_sc) begin
        mem_wreg  = ex_wreg;
        mem_wdata = sc_result;
      end
      if (misalign) begin
        mem_wreg = 1'b0;
        mem_adel = is_ld;
        mem_ades = is_st;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, load extension, store lane
// steering with delayed grant, misalignment, reset mid-access and LL/SC
// (the LL/SC part follows MEM_LLSC_EN).
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic        ex_whilo;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr, ex_reg2;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo, stallreq_mem, mem_adel, mem_ades;
  logic        dbus_req, dbus_we;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_addr, dbus_wdata;
  logic        llbit_clr;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .ex_wd        (ex_wd),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (ex_wdata),
    .ex_hi        (ex_hi),
    .ex_lo        (ex_lo),
    .ex_whilo     (ex_whilo),
    .ex_aluop     (ex_aluop),
    .ex_mem_addr  (ex_mem_addr),
    .ex_reg2      (ex_reg2),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .mem_whilo    (mem_whilo),
    .stallreq_mem (stallreq_mem),
    .mem_adel     (mem_adel),
    .mem_ades     (mem_ades),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_be      (dbus_be),
    .dbus_addr    (dbus_addr),
    .dbus_wdata   (dbus_wdata),
`ifdef MEM_LLSC_EN
    .llbit_clr    (llbit_clr),
`endif
    .dbus_gnt     (dbus_gnt),
    .dbus_rvalid  (dbus_rvalid),
    .dbus_rdata   (dbus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] wdata, input logic wreg);
    ex_wd       = 5'd7;
    ex_wreg     = wreg;
    ex_wdata    = wdata;
    ex_hi       = 32'h1111_2222;
    ex_lo       = 32'h3333_4444;
    ex_whilo    = (op == EXE_ADDU_OP);
    ex_aluop    = op;
    ex_mem_addr = addr;
    ex_reg2     = reg2;
  endtask

  // Drives one bus access: grant after gnt_dly cycles, response the cycle
  // after, and spurious rvalid pulses while waiting for the grant. Leaves
  // time at the negedge of the DONE cycle.
  task automatic mem_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input int gnt_dly, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic exp_we);
    int stalls;
    stalls = 0;
    set_ex(op, addr, reg2, 32'h0, 1'b1);
    for (int c = 0; c <= gnt_dly + 1; c++) begin
      dbus_gnt    = (c == gnt_dly);
      dbus_rvalid = (c == gnt_dly + 1) || (c < gnt_dly);
      dbus_rdata  = (c == gnt_dly + 1) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      if (stallreq_mem) stalls++;
      chk({tag, " req"}, {31'd0, dbus_req}, {31'd0, (c <= gnt_dly)});
      if (c <= gnt_dly) begin
        chk({tag, " addr"}, dbus_addr, {addr[31:2], 2'b00});
        chk({tag, " be"}, {28'd0, dbus_be}, {28'd0, exp_be});
        chk({tag, " bus wdata"}, dbus_wdata, exp_wd);
        chk({tag, " we"}, {31'd0, dbus_we}, {31'd0, exp_we});
      end
      next_cyc();
    end
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    chk({tag, " stall cycles"}, 32'(stalls), 32'(gnt_dly + 2));
    chk({tag, " done stall"}, {31'd0, stallreq_mem}, 32'd0);
  endtask

  task automatic finish_op();
    set_ex(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 1'b0);
    next_cyc();
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab[6];

  initial begin
    ld_tab[0] = '{EXE_LB_OP,  32'h0000_1003, 32'h80FF_FFFF, 4'b1000, 32'hFFFF_FF80};
    ld_tab[1] = '{EXE_LBU_OP, 32'h0000_1003, 32'h80FF_FFFF, 4'b1000, 32'h0000_0080};
    ld_tab[2] = '{EXE_LH_OP,  32'h0000_1002, 32'h8001_FFFF, 4'b1100, 32'hFFFF_8001};
    ld_tab[3] = '{EXE_LHU_OP, 32'h0000_1002, 32'h8001_FFFF, 4'b1100, 32'h0000_8001};
    ld_tab[4] = '{EXE_LB_OP,  32'h0000_1001, 32'h0000_7F00, 4'b0010, 32'h0000_007F};
    ld_tab[5] = '{EXE_LW_OP,  32'h0000_1000, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE};

    rst = 1'b1;
    llbit_clr = 1'b0;
    dbus_gnt = 1'b0;
    dbus_rvalid = 1'b0;
    dbus_rdata = 32'h0;
    set_ex(EXE_ADDU_OP, 32'h0, 32'h0, 32'h1234_5678, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset mem_wreg", {31'd0, mem_wreg}, 32'd0);
    chk("reset mem_hi", mem_hi, 32'h0);
    chk("reset stall", {31'd0, stallreq_mem}, 32'd0);
    chk("reset req", {31'd0, dbus_req}, 32'd0);

    rst = 1'b0;
    next_cyc();
    @(negedge clk);
    chk("addu wdata", mem_wdata, 32'h1234_5678);
    chk("addu wreg", {31'd0, mem_wreg}, 32'd1);
    chk("addu wd", {27'd0, mem_wd}, 32'd7);
    chk("addu hi", mem_hi, 32'h1111_2222);
    chk("addu lo", mem_lo, 32'h3333_4444);
    chk("addu whilo", {31'd0, mem_whilo}, 32'd1);
    chk("addu stall", {31'd0, stallreq_mem}, 32'd0);
    chk("addu req", {31'd0, dbus_req}, 32'd0);
    finish_op();

    for (int i = 0; i < 6; i++) begin
      mem_op($sformatf("load%0d", i), ld_tab[i].op, ld_tab[i].addr, 32'h0, 0,
             ld_tab[i].rdata, ld_tab[i].be, 32'h0, 1'b0);
      chk($sformatf("load%0d result", i), mem_wdata, ld_tab[i].exp);
      chk($sformatf("load%0d wreg", i), {31'd0, mem_wreg}, 32'd1);
      finish_op();
    end

    mem_op("sh", EXE_SH_OP, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0, 4'b1100, 32'hABCD_ABCD, 1'b1);
    chk("sh wreg", {31'd0, mem_wreg}, 32'd0);
    finish_op();
    mem_op("sb", EXE_SB_OP, 32'h0000_2001, 32'h0000_005A, 1, 32'h0, 4'b0010, 32'h5A5A_5A5A, 1'b1);
    chk("sb wreg", {31'd0, mem_wreg}, 32'd0);
    finish_op();
    mem_op("sw", EXE_SW_OP, 32'h0000_2000, 32'h8765_4321, 0, 32'h0, 4'b1111, 32'h8765_4321, 1'b1);
    finish_op();

    set_ex(EXE_LW_OP, 32'h0000_3001, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("lw mis req", {31'd0, dbus_req}, 32'd0);
    chk("lw mis stall", {31'd0, stallreq_mem}, 32'd0);
    chk("lw mis adel", {31'd0, mem_adel}, 32'd1);
    chk("lw mis ades", {31'd0, mem_ades}, 32'd0);
    chk("lw mis wreg", {31'd0, mem_wreg}, 32'd0);
    finish_op();
    @(negedge clk);
    chk("adel pulse end", {31'd0, mem_adel}, 32'd0);
    set_ex(EXE_SH_OP, 32'h0000_2001, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("sh mis ades", {31'd0, mem_ades}, 32'd1);
    chk("sh mis req", {31'd0, dbus_req}, 32'd0);
    finish_op();

    // Reset while waiting for the response, then a late response.
    set_ex(EXE_LW_OP, 32'h0000_0100, 32'h0, 32'h0, 1'b1);
    dbus_gnt = 1'b1;
    @(negedge clk);
    chk("rst lw req", {31'd0, dbus_req}, 32'd1);
    next_cyc();
    dbus_gnt = 1'b0;
    @(negedge clk);
    chk("rst lw wait stall", {31'd0, stallreq_mem}, 32'd1);
    rst = 1'b1;
    next_cyc();
    dbus_rvalid = 1'b1;
    dbus_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("rst mid wdata", mem_wdata, 32'h0);
    chk("rst mid stall", {31'd0, stallreq_mem}, 32'd0);
    chk("rst mid req", {31'd0, dbus_req}, 32'd0);
    set_ex(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    next_cyc();
    @(negedge clk);
    chk("late rvalid stall", {31'd0, stallreq_mem}, 32'd0);
    dbus_rvalid = 1'b0;
    next_cyc();
    mem_op("post-rst lw", EXE_LW_OP, 32'h0000_0200, 32'h0, 0, 32'h0BAD_F00D, 4'b1111, 32'h0, 1'b0);
    chk("post-rst lw result", mem_wdata, 32'h0BAD_F00D);
    finish_op();

`ifdef MEM_LLSC_EN
    mem_op("ll", EXE_LL_OP, 32'h0000_0040, 32'h0, 0, 32'h0000_0012, 4'b1111, 32'h0, 1'b0);
    chk("ll result", mem_wdata, 32'h0000_0012);
    finish_op();
    mem_op("sc ok", EXE_SC_OP, 32'h0000_0044, 32'hFEED_FACE, 0, 32'h0, 4'b1111, 32'hFEED_FACE, 1'b1);
    chk("sc ok rd", mem_wdata, 32'd1);
    chk("sc ok wreg", {31'd0, mem_wreg}, 32'd1);
    finish_op();
    mem_op("ll2", EXE_LL_OP, 32'h0000_0040, 32'h0, 0, 32'h0000_0034, 4'b1111, 32'h0, 1'b0);
    finish_op();
    llbit_clr = 1'b1;
    next_cyc();
    llbit_clr = 1'b0;
    set_ex(EXE_SC_OP, 32'h0000_0048, 32'h1357_9BDF, 32'h0, 1'b1);
    @(negedge clk);
    chk("sc fail req", {31'd0, dbus_req}, 32'd0);
    chk("sc fail stall", {31'd0, stallreq_mem}, 32'd0);
    chk("sc fail rd", mem_wdata, 32'd0);
    chk("sc fail wreg", {31'd0, mem_wreg}, 32'd1);
    finish_op();
`else
    mem_op("sc", EXE_SC_OP, 32'h0000_0044, 32'hFEED_FACE, 0, 32'h0, 4'b1111, 32'hFEED_FACE, 1'b1);
    chk("sc rd", mem_wdata, 32'd1);
    chk("sc wreg", {31'd0, mem_wreg}, 32'd1);
    finish_op();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage of the 5-stage MIPS32 core. It sits between the `ex_mem` pipeline register and `mem_wb`, and forwards register, HI and LO write-back information to `mem_wb`. For load and store ops it runs a request/grant/response handshake on the data bus, holding the pipeline through `stallreq_mem` until the access completes. It performs byte-lane steering for stores, and sign or zero extension for loads.

## Interface
Parameters: none (all widths come from `defines.svh`).

- `clk` input 1: clock
- `rst` input 1: reset, synchronous, active-high
- `ex_wd` input `RegAddrBus` (5): destination register
- `ex_wreg` input 1: register write enable
- `ex_wdata` input `RegBus` (32): ALU result, passed through for non-load ops
- `ex_hi`, `ex_lo` input 32 each: HI/LO values
- `ex_whilo` input 1: HI/LO write enable
- `ex_aluop` input 8: operation code
- `ex_mem_addr` input 32: effective address
- `ex_reg2` input 32: store data
- `mem_wd`, `mem_wreg`, `mem_wdata`, `mem_hi`, `mem_lo`, `mem_whilo` output (same widths as the inputs): to `mem_wb`
- `stallreq_mem` output 1: stall request to `ctrl`
- `mem_adel`, `mem_ades` output 1 each: load/store address-error pulse
- `dbus_req` output 1: access request
- `dbus_we` output 1: write
- `dbus_be` output 4: byte enables
- `dbus_addr` output 32: word-aligned address, bits [1:0] = 0
- `dbus_wdata` output 32: lane-steered store data
- `dbus_gnt` input 1: request accepted this cycle
- `dbus_rvalid` input 1: response valid
- `dbus_rdata` input 32: read data
- `llbit_clr` input 1: clear LL bit (exception or eret); present only with `MEM_LLSC_EN`

## Operation
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW, plus LL and SC. Every other op passes straight through combinationally, with `stallreq_mem` = 0.
- Little-endian; byte lane = `ex_mem_addr[1:0]`.
- Byte enables: SB = `4'b0001 << addr[1:0]`; SH = `4'b0011 << addr[1:0]`; SW = `4'b1111`.
- Store data is replicated across lanes: byte ×4, halfword ×2, or the full word.
- Alignment: LH/LHU/SH need `addr[0]` = 0; LW/SW/LL/SC need `addr[1:0]` = 0.
- A misaligned op issues no bus access, forces `mem_wreg` = 0 and pulses `mem_adel` (loads) or `mem_ades` (stores) for one cycle. It does not stall.
- State machine states:
  - IDLE: on an aligned memory op, drive `dbus_req` = 1. If `dbus_gnt` is 1 the same cycle, go to WAIT_DATA; otherwise go to WAIT_GNT.
  - WAIT_GNT: hold `dbus_req` with stable address, byte enables and data. Go to WAIT_DATA on `dbus_gnt`.
  - WAIT_DATA: `dbus_req` = 0. On `dbus_rvalid`, register `dbus_rdata` into `rdata_q` and go to DONE. Stores also wait for `dbus_rvalid` (write acknowledge).
  - DONE: `stallreq_mem` = 0 and outputs carry the final result. Go to IDLE unconditionally after one cycle.
- `stallreq_mem` = aligned memory op AND state ≠ DONE.
- Load result comes from `rdata_q`:
  - LB/LBU: selected byte, sign- or zero-extended.
  - LH/LHU: selected halfword, sign- or zero-extended.
  - LW: full word.
- Stores force `mem_wreg` = 0 (except SC).
- HI/LO fields always pass through unchanged.
- `dbus_rvalid` in IDLE, WAIT_GNT or DONE is ignored.

## Timing
- Reset: every output 0, `dbus_req` = 0, state = IDLE, `rdata_q` = 0, LL bit = 0.
- Reset mid-access: abandon the access; any later response is ignored.
- `dbus_req` is combinational, gated by `!rst`.
- The bus never asserts `dbus_rvalid` in the grant cycle.
- Minimum memory-op occupancy is 3 cycles: grant in cycle 0, `dbus_rvalid` in cycle 1, DONE in cycle 2.
- `ex_*` inputs are stable during a stall, because `ctrl` stalls `ex_mem`.
- Exactly one bus request is issued per instruction.

## Configuration
- `MEM_LLSC_EN` defined:
  - LL behaves as LW and then sets the LL bit in DONE.
  - SC with LL bit = 1 does a word store and writes 1 to `ex_wd`.
  - SC with LL bit = 0 issues no bus access, writes 0 to `ex_wd`, and does not stall.
  - SC clears the LL bit in its final cycle.
  - `llbit_clr` clears the LL bit and takes priority over a same-cycle LL set.
- `MEM_LLSC_EN` undefined: no LL bit and no `llbit_clr` port. LL behaves as LW; SC behaves as SW and writes 1 to `ex_wd`.

## Structure
- Shared package/defines: aluop constants `EXE_LB_OP` through `EXE_SC_OP`, the state enum `mem_state_t`, `RegBus` and `RegAddrBus`.
- Sub-module `mem_load_align` (combinational): inputs `rdata_q`, aluop and `addr[1:0]`; output is the extended load result.

## Test plan
- ADDU result 0x12345678, `ex_wreg` = 1 → same-cycle pass-through, `stallreq_mem` = 0, `dbus_req` = 0.
- LB at 0x1003, `dbus_rdata` = 0x80FFFFFF, gnt in cycle 0, rvalid in cycle 1 → `mem_wdata` = 0xFFFFFF80 in cycle 2. Repeat as LBU → 0x00000080. Stall lasts 2 cycles.
- SH at 0x2002, data 0xABCD, gnt delayed 3 cycles → `dbus_req` held stable, `dbus_be` = 0b1100, `dbus_wdata` = 0xABCDABCD, `mem_wreg` = 0.
- LW at 0x3001 → no `dbus_req`, `mem_adel` pulses once, `mem_wreg` = 0, no stall.
- `rst` asserted in WAIT_DATA, then `dbus_rvalid` arrives → outputs 0, state IDLE, response ignored.
- `MEM_LLSC_EN`: LL at 0x40, then SC → store issued and rd = 1. Repeat with `llbit_clr` between the two → no bus access and rd = 0.
